// File: rtl/fft8_pkg.sv
// Shared types, sizes, twiddle ROM and index helpers for the 8-point sequential IFFT.
package fft8_pkg;

  localparam int unsigned DW     = 32;
  localparam int unsigned FRAC   = 16;
  localparam int unsigned N      = 8;
  localparam int unsigned LOG2N  = 3;
  localparam int unsigned PW     = 2 * DW;
  localparam int unsigned N_BFLY = (N / 2) * LOG2N;
  localparam int unsigned CC_W   = 4;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} state_e;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } cplx_t;

  // Inverse-transform twiddles W^j = cos(2*pi*j/8) + j*sin(2*pi*j/8), Q16.16
  localparam logic [DW-1:0] TW_COS [N/2] = '{32'h0001_0000, 32'h0000_B505, 32'h0000_0000, 32'hFFFF_4AFB};
  localparam logic [DW-1:0] TW_SIN [N/2] = '{32'h0000_0000, 32'h0000_B505, 32'h0001_0000, 32'h0000_B505};

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/ifft8_bfly.sv
// Combinational radix-2 butterfly: y0 = a + b*w, y1 = a - b*w (Q16.16).
// IFFT8_ROUND_EN: round half up on the product slice instead of truncating.
module ifft8_bfly
  import fft8_pkg::*;
(
  input  cplx_t a,
  input  cplx_t b,
  input  cplx_t w,
  output cplx_t y0_c,
  output cplx_t y1_c
);

`ifdef IFFT8_ROUND_EN
  localparam logic signed [PW-1:0] PROD_RND = PW'(32'h0000_8000);
`else
  localparam logic signed [PW-1:0] PROD_RND = '0;
`endif

  logic signed [PW-1:0] prod_re;
  logic signed [PW-1:0] prod_im;
  logic [DW-1:0]        t_re;
  logic [DW-1:0]        t_im;

  // Full-precision complex product, then keep bits [47:16]
  always_comb begin
    prod_re = PW'($signed(b.re)) * PW'($signed(w.re)) - PW'($signed(b.im)) * PW'($signed(w.im));
    prod_im = PW'($signed(b.re)) * PW'($signed(w.im)) + PW'($signed(b.im)) * PW'($signed(w.re));
    t_re    = DW'((prod_re + PROD_RND) >>> FRAC);
    t_im    = DW'((prod_im + PROD_RND) >>> FRAC);
    y0_c.re = a.re + t_re;
    y0_c.im = a.im + t_im;
    y1_c.re = a.re - t_re;
    y1_c.im = a.im - t_im;
  end

endmodule

// File: rtl/ifft_8point_seq.sv
// Sequential 8-point radix-2 DIT inverse FFT with one shared butterfly, outputs scaled by 1/8.
// IFFT8_ROUND_EN: round half up in the butterfly and in the output scaling.
module ifft_8point_seq
  import fft8_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_r,
  input  logic [DW-1:0] in_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_r,
  output logic [DW-1:0] out_i,
  output logic          out_last,
  output logic          busy
);

`ifdef IFFT8_ROUND_EN
  localparam logic [DW-1:0] OUT_RND = DW'(4);
`else
  localparam logic [DW-1:0] OUT_RND = '0;
`endif

  state_e           state;
  cplx_t            x [N];
  logic [LOG2N-1:0] ld_cnt;
  logic [LOG2N-1:0] out_idx;
  logic [CC_W-1:0]  cc;

  logic [1:0]       stg;
  logic [1:0]       bf;
  logic [1:0]       tw_idx;
  logic [LOG2N-1:0] p_idx;
  logic [LOG2N-1:0] q_idx;
  logic [LOG2N-1:0] nxt_idx;
  cplx_t            w;
  cplx_t            y0;
  cplx_t            y1;

  function automatic logic [DW-1:0] scale_out(input logic [DW-1:0] v);
    logic signed [DW-1:0] s;
    s = $signed(v + OUT_RND);
    return DW'(s >>> LOG2N);
  endfunction

  // Butterfly schedule: pair (p, q=p+h) and twiddle index for stage stg, butterfly bf
  always_comb begin
    stg     = cc[3:2];
    bf      = cc[1:0];
    p_idx   = '0;
    q_idx   = '0;
    tw_idx  = '0;
    nxt_idx = LOG2N'(out_idx + 1'b1);
    case (stg)
      2'd0: begin
        p_idx  = {bf, 1'b0};
        q_idx  = {bf, 1'b1};
        tw_idx = 2'd0;
      end
      2'd1: begin
        p_idx  = {bf[1], 1'b0, bf[0]};
        q_idx  = {bf[1], 1'b1, bf[0]};
        tw_idx = {bf[0], 1'b0};
      end
      default: begin
        p_idx  = {1'b0, bf};
        q_idx  = {1'b1, bf};
        tw_idx = bf;
      end
    endcase
    w.re = TW_COS[tw_idx];
    w.im = TW_SIN[tw_idx];
  end

  ifft8_bfly u_bfly (
    .a    (x[p_idx]),
    .b    (x[q_idx]),
    .w    (w),
    .y0_c (y0),
    .y1_c (y1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      busy      <= 1'b0;
      ld_cnt    <= '0;
      out_idx   <= '0;
      cc        <= '0;
      for (int i = 0; i < int'(N); i++) x[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= LOAD;
          in_ready <= 1'b1;
        end
        // Bins land in bit-reversed order so the DIT stages run in place
        LOAD: begin
          if (in_valid && in_ready) begin
            x[bitrev3(ld_cnt)].re <= in_r;
            x[bitrev3(ld_cnt)].im <= in_i;
            ld_cnt                <= LOG2N'(ld_cnt + 1'b1);
            if (ld_cnt == LOG2N'(N - 1)) begin
              state    <= COMPUTE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              cc       <= '0;
            end
          end
        end
        COMPUTE: begin
          x[p_idx] <= y0;
          x[q_idx] <= y1;
          cc       <= CC_W'(cc + 1'b1);
          if (cc == CC_W'(N_BFLY - 1)) begin
            state   <= UNLOAD;
            out_idx <= '0;
          end
        end
        // First UNLOAD cycle registers sample 0; afterwards advance on handshake
        UNLOAD: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_r     <= scale_out(x[out_idx].re);
            out_i     <= scale_out(x[out_idx].im);
            out_last  <= (out_idx == LOG2N'(N - 1));
          end else if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              out_idx   <= '0;
              state     <= LOAD;
            end else begin
              out_idx  <= nxt_idx;
              out_r    <= scale_out(x[nxt_idx].re);
              out_i    <= scale_out(x[nxt_idx].im);
              out_last <= (nxt_idx == LOG2N'(N - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
